conv_frame_capture: RTL and testbench
=====================================

// Module: conv_frame_capture
// PURPOSE
//  Receiving end of the convolution pixel stream. Captures outputPixel words into an
//  on-chip frame buffer in the bottom-left to top-right scan order used by the input
//  side, and offers a random-access readback port for export or next-stage consumption.
//  Sits directly downstream of convolution.
// PARAMETERS
//  WORD_SIZE     8    bits per pixel
//  ROW_SIZE      540  pixels per row (image width)
//  IMAGE_HEIGHT  360  rows per frame
//  SKIP          0    valid pixels discarded after start (convolution pipeline fill)
//  ADDR_W        $clog2(ROW_SIZE*IMAGE_HEIGHT)  derived; do not override
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          asynchronous reset, active-low
//  start        in   1          1-cycle pulse: arm a new frame capture
//  pixel_valid  in   1          pixel_in qualifies this cycle
//  pixel_in     in   WORD_SIZE  pixel from convolution outputPixel
//  busy         out  1          1 in SKIP or CAPTURE
//  frame_done   out  1          1-cycle pulse when the last pixel is written
//  overflow     out  1          sticky: valid pixel arrived while not armed
//  rd_en        in   1          readback request
//  rd_addr      in   ADDR_W     linear address = row*ROW_SIZE + col (row 0 = top)
//  rd_data      out  WORD_SIZE  readback data
//  rd_valid     out  1          rd_data valid; 1 cycle after accepted rd_en
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; busy, frame_done, overflow, rd_valid, rd_data = 0;
//   row=IMAGE_HEIGHT-1, col=0, skip_cnt=0. RAM contents are not cleared.
//  FSM:
//   IDLE    : start -> SKIP if SKIP>0, else CAPTURE.
//   SKIP    : each pixel_valid increments skip_cnt; skip_cnt==SKIP-1 with valid -> CAPTURE.
//   CAPTURE : each pixel_valid writes pixel_in to addr row*ROW_SIZE+col.
//             col++; at col==ROW_SIZE-1, col=0 and row--.
//             Write at row==0 && col==ROW_SIZE-1 -> frame_done pulse the next cycle, -> DONE.
//   DONE    : holds; start -> re-arm (as from IDLE).
//  start always clears skip_cnt, resets row/col and clears overflow.
//  start in SKIP or CAPTURE restarts the capture; the partial frame is abandoned.
//  start and pixel_valid in the same cycle: the pixel is treated as the first pixel after
//   start (counted as skip, or written to row H-1 col 0 when SKIP=0).
//  pixel_valid in IDLE or DONE: pixel dropped, overflow<=1 (sticky until start or reset).
//  Gaps in pixel_valid are allowed anywhere; counters only advance on valid.
//  Readback: accepted only when busy==0. rd_en while busy is ignored (rd_valid stays 0).
//   Latency is 1 cycle, synchronous read. rd_addr >= ROW_SIZE*IMAGE_HEIGHT returns 0 with
//   rd_valid=1.
//  Address arithmetic: row*ROW_SIZE+col is computed as an incrementally maintained
//   base_addr (base -= ROW_SIZE per row), with no multiplier. All counters are unsigned,
//   ADDR_W wide.
// STRUCTURE
//  Package conv_pkg: cap_state_t enum {IDLE,SKIP,CAPTURE,DONE}; shared WORD_SIZE,
//   ROW_SIZE and IMAGE_HEIGHT defaults.
//  Sub-module frame_ram: 1W/1R simple dual-port sync RAM, depth ROW_SIZE*IMAGE_HEIGHT,
//   width WORD_SIZE, registered read.
// TESTING (ROW_SIZE=4, IMAGE_HEIGHT=3, SKIP=2 unless noted)
//  1 Full frame: start, then 14 valid pixels 0x00..0x0D -> 0x00/0x01 skipped; addr 8..11 =
//    02..05, 4..7 = 06..09, 0..3 = 0A..0D; frame_done pulses once; busy low after.
//  2 Gapped valid (1 valid every 3 cycles) -> RAM image identical to test 1.
//  3 Restart: start, 7 pixels, start, 14 pixels 0x10.. -> image as test 1 offset by 0x10;
//    one frame_done.
//  4 Overflow: 3 valid pixels after DONE -> overflow=1, RAM unchanged; next start clears it.
//  5 Readback: rd_en at addr 0 and 11 on consecutive cycles -> rd_data 0x0A then 0x05,
//    each 1 cycle later; rd_en while busy -> rd_valid stays 0; addr 12 -> 0x00.
//  6 Reset mid-CAPTURE (rst low for 1 cycle) -> all outputs 0 immediately, IDLE;
//    SKIP=0 variant: start+valid same cycle writes addr 8.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution frame-capture path.
package conv_pkg;

   localparam int unsigned WORD_SIZE_DEF    = 8;
   localparam int unsigned ROW_SIZE_DEF     = 540;
   localparam int unsigned IMAGE_HEIGHT_DEF = 360;
   localparam int unsigned SKIP_DEF         = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SKIP,
      ST_CAPTURE,
      ST_DONE
   } cap_state_t;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// Reads beyond DEPTH return zero so the top can pass any address straight through.
module frame_ram #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Storage array carries no reset so it maps onto a RAM macro.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_rdata <= '0;
      else if (i_re) r_rdata <= (32'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/conv_frame_capture.sv
// Captures the convolution output stream into a frame buffer, bottom row first,
// and serves random-access readback whenever no capture is in progress.
module conv_frame_capture
   import conv_pkg::*;
#(
   parameter int unsigned WORD_SIZE    = WORD_SIZE_DEF,
   parameter int unsigned ROW_SIZE     = ROW_SIZE_DEF,
   parameter int unsigned IMAGE_HEIGHT = IMAGE_HEIGHT_DEF,
   parameter int unsigned SKIP         = SKIP_DEF,
   parameter int unsigned ADDR_W       = $clog2(ROW_SIZE*IMAGE_HEIGHT)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 pixel_valid,
   input  logic [WORD_SIZE-1:0] pixel_in,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 overflow,
   input  logic                 rd_en,
   input  logic [ADDR_W-1:0]    rd_addr,
   output logic [WORD_SIZE-1:0] rd_data,
   output logic                 rd_valid
);

   localparam int unsigned       DEPTH      = ROW_SIZE*IMAGE_HEIGHT;
   localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(ROW_SIZE-1);
   localparam logic [ADDR_W-1:0] ROW_FIRST  = ADDR_W'(IMAGE_HEIGHT-1);
   localparam logic [ADDR_W-1:0] BASE_FIRST = ADDR_W'((IMAGE_HEIGHT-1)*ROW_SIZE);
   localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(ROW_SIZE);
   localparam logic [ADDR_W-1:0] SKIP_LAST  = ADDR_W'((SKIP > 0) ? SKIP-1 : 0);
   localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
   localparam cap_state_t        ARM_STATE  = (SKIP > 0) ? ST_SKIP : ST_CAPTURE;

   cap_state_t        r_state, w_state_cur, w_state_nxt;
   logic [ADDR_W-1:0] r_row, w_row_cur, w_row_nxt;
   logic [ADDR_W-1:0] r_col, w_col_cur, w_col_nxt;
   logic [ADDR_W-1:0] r_base, w_base_cur, w_base_nxt;
   logic [ADDR_W-1:0] r_skip_cnt, w_skip_cur, w_skip_nxt;
   logic              r_busy, r_frame_done, r_overflow, r_rd_valid;
   logic              w_we, w_done, w_ovf_set, w_rd_accept;
   logic [ADDR_W-1:0] w_waddr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_row        <= ROW_FIRST;
         r_col        <= '0;
         r_base       <= BASE_FIRST;
         r_skip_cnt   <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
         r_rd_valid   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_row        <= w_row_nxt;
         r_col        <= w_col_nxt;
         r_base       <= w_base_nxt;
         r_skip_cnt   <= w_skip_nxt;
         r_busy       <= (w_state_nxt == ST_SKIP) || (w_state_nxt == ST_CAPTURE);
         r_frame_done <= w_done;
         r_overflow   <= start ? 1'b0 : (r_overflow | w_ovf_set);
         r_rd_valid   <= w_rd_accept;
      end
   end

   // start re-arms first, so a pixel in the same cycle is processed as the first one.
   always_comb begin
      w_state_cur = start ? ARM_STATE  : r_state;
      w_row_cur   = start ? ROW_FIRST  : r_row;
      w_col_cur   = start ? '0         : r_col;
      w_base_cur  = start ? BASE_FIRST : r_base;
      w_skip_cur  = start ? '0         : r_skip_cnt;
      w_state_nxt = w_state_cur;
      w_row_nxt   = w_row_cur;
      w_col_nxt   = w_col_cur;
      w_base_nxt  = w_base_cur;
      w_skip_nxt  = w_skip_cur;
      w_we        = 1'b0;
      w_done      = 1'b0;
      w_ovf_set   = 1'b0;
      case (w_state_cur)
         ST_SKIP: begin
            if (pixel_valid) begin
               if (w_skip_cur == SKIP_LAST) w_state_nxt = ST_CAPTURE;
               else                         w_skip_nxt  = w_skip_cur + ONE;
            end
         end
         ST_CAPTURE: begin
            if (pixel_valid) begin
               w_we = 1'b1;
               if (w_col_cur == COL_LAST) begin
                  w_col_nxt = '0;
                  if (w_row_cur == '0) begin
                     w_state_nxt = ST_DONE;
                     w_done      = 1'b1;
                  end else begin
                     w_row_nxt  = w_row_cur - ONE;
                     w_base_nxt = w_base_cur - ROW_STEP;
                  end
               end else begin
                  w_col_nxt = w_col_cur + ONE;
               end
            end
         end
         default: w_ovf_set = pixel_valid;
      endcase
   end

   assign w_waddr     = w_base_cur + w_col_cur;
   assign w_rd_accept = rd_en && !r_busy;

   frame_ram #(
      .WIDTH (WORD_SIZE),
      .DEPTH (DEPTH),
      .AW    (ADDR_W)
   ) u_frame_ram (
      .clk     (clk),
      .rst_n   (rst),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (pixel_in),
      .i_re    (w_rd_accept),
      .i_raddr (rd_addr),
      .o_rdata (rd_data)
   );

   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign overflow   = r_overflow;
   assign rd_valid   = r_rd_valid;

endmodule

// File: tb/tb_conv_frame_capture.sv
// Scenario bench for conv_frame_capture on a 4x3 frame (SKIP=2, plus a SKIP=0 instance).
module tb_conv_frame_capture;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, pixel_valid, rd_en;
   logic [7:0] pixel_in;
   logic [3:0] rd_addr;
   logic       busy, frame_done, overflow, rd_valid;
   logic [7:0] rd_data;

   logic       s0_start, s0_pixel_valid, s0_rd_en;
   logic [7:0] s0_pixel_in;
   logic [3:0] s0_rd_addr;
   logic       s0_busy, s0_frame_done, s0_overflow, s0_rd_valid;
   logic [7:0] s0_rd_data;

   int         n_cmp = 0;
   int         n_err = 0;
   int         done_cnt = 0;
   int         done0_cnt = 0;
   logic [7:0] sb [$];

   always #5 clk = ~clk;

   conv_frame_capture #(.WORD_SIZE(8), .ROW_SIZE(4), .IMAGE_HEIGHT(3), .SKIP(2)) u_dut (
      .clk(clk), .rst(rst), .start(start), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
      .busy(busy), .frame_done(frame_done), .overflow(overflow),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
   );

   conv_frame_capture #(.WORD_SIZE(8), .ROW_SIZE(4), .IMAGE_HEIGHT(3), .SKIP(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(s0_start), .pixel_valid(s0_pixel_valid), .pixel_in(s0_pixel_in),
      .busy(s0_busy), .frame_done(s0_frame_done), .overflow(s0_overflow),
      .rd_en(s0_rd_en), .rd_addr(s0_rd_addr), .rd_data(s0_rd_data), .rd_valid(s0_rd_valid)
   );

   always @(negedge clk) begin
      if (frame_done === 1'b1)    done_cnt++;
      if (s0_frame_done === 1'b1) done0_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic feed(input logic [7:0] first, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         pixel_valid = 1'b1;
         pixel_in    = first + 8'(i);
         tick();
         pixel_valid = 1'b0;
         repeat (gap) tick();
      end
   endtask

   task automatic rd_issue(input logic [3:0] a);
      rd_en   = 1'b1;
      rd_addr = a;
      tick();
      rd_en   = 1'b0;
   endtask

   // Pixel k after the skipped ones lands at row 2-k/4, col k%4 and carries value k+2.
   function automatic logic [7:0] exp_pix(input int a, input logic [7:0] off);
      return 8'(((2 - a/4)*4 + a%4) + 2) + off;
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({busy, frame_done, overflow, rd_valid, rd_data} !== 12'h000 ||
          {s0_busy, s0_frame_done, s0_overflow, s0_rd_valid, s0_rd_data} !== 12'h000) begin
         n_err++;
         $display("FAIL reset_outputs: got %h/%h, want 000/000",
                  {busy, frame_done, overflow, rd_valid, rd_data},
                  {s0_busy, s0_frame_done, s0_overflow, s0_rd_valid, s0_rd_data});
      end
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_full_frame();
      int         d0;
      logic [7:0] e;
      d0 = done_cnt;
      pulse_start();
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy: got %b, want 1", busy); end
      feed(8'h00, 14, 0);
      tick();
      n_cmp++;
      if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL full_done: got done=%0d busy=%b, want done=1 busy=0", done_cnt - d0, busy);
      end
      for (int a = 0; a < 12; a++) begin
         sb.push_back(exp_pix(a, 8'h00));
         rd_issue(4'(a));
         e = sb.pop_front();
         n_cmp++;
         if (rd_valid !== 1'b1 || rd_data !== e) begin
            n_err++;
            $display("FAIL full_img addr %0d: got v=%b d=%h, want v=1 d=%h", a, rd_valid, rd_data, e);
         end
      end
   endtask

   task automatic test_restart();
      int         d0;
      logic [7:0] e;
      d0 = done_cnt;
      pulse_start();
      feed(8'h20, 7, 0);
      pulse_start();
      feed(8'h10, 14, 0);
      tick();
      n_cmp++;
      if (done_cnt - d0 !== 1) begin
         n_err++;
         $display("FAIL restart_done: got %0d pulses, want 1", done_cnt - d0);
      end
      for (int a = 0; a < 12; a++) begin
         sb.push_back(exp_pix(a, 8'h10));
         rd_issue(4'(a));
         e = sb.pop_front();
         n_cmp++;
         if (rd_valid !== 1'b1 || rd_data !== e) begin
            n_err++;
            $display("FAIL restart_img addr %0d: got v=%b d=%h, want v=1 d=%h", a, rd_valid, rd_data, e);
         end
      end
   endtask

   task automatic test_gapped();
      int         d0;
      logic [7:0] e;
      d0 = done_cnt;
      pulse_start();
      feed(8'h00, 14, 2);
      tick();
      n_cmp++;
      if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL gapped_done: got done=%0d busy=%b, want done=1 busy=0", done_cnt - d0, busy);
      end
      for (int a = 0; a < 12; a++) begin
         sb.push_back(exp_pix(a, 8'h00));
         rd_issue(4'(a));
         e = sb.pop_front();
         n_cmp++;
         if (rd_valid !== 1'b1 || rd_data !== e) begin
            n_err++;
            $display("FAIL gapped_img addr %0d: got v=%b d=%h, want v=1 d=%h", a, rd_valid, rd_data, e);
         end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] e;
      n_cmp++;
      if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_pre: got %b, want 0", overflow); end
      feed(8'hF0, 3, 0);
      n_cmp++;
      if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b, want 1", overflow); end
      for (int a = 0; a < 12; a++) begin
         sb.push_back(exp_pix(a, 8'h00));
         rd_issue(4'(a));
         e = sb.pop_front();
         n_cmp++;
         if (rd_valid !== 1'b1 || rd_data !== e) begin
            n_err++;
            $display("FAIL ovf_img addr %0d: got v=%b d=%h, want v=1 d=%h", a, rd_valid, rd_data, e);
         end
      end
      n_cmp++;
      if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b, want 1", overflow); end
      pulse_start();
      n_cmp++;
      if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b, want 0", overflow); end
      feed(8'h00, 14, 0);
      tick();
   endtask

   task automatic test_readback();
      logic [7:0] e;
      sb.push_back(8'h0A);
      sb.push_back(8'h05);
      rd_en   = 1'b1;
      rd_addr = 4'd0;
      tick();
      rd_addr = 4'd11;
      e = sb.pop_front();
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
         n_err++;
         $display("FAIL rd_b2b0: got v=%b d=%h, want v=1 d=%h", rd_valid, rd_data, e);
      end
      tick();
      rd_en = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
         n_err++;
         $display("FAIL rd_b2b1: got v=%b d=%h, want v=1 d=%h", rd_valid, rd_data, e);
      end
      sb.push_back(8'h00);
      rd_issue(4'd12);
      e = sb.pop_front();
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
         n_err++;
         $display("FAIL rd_oob: got v=%b d=%h, want v=1 d=%h", rd_valid, rd_data, e);
      end
      pulse_start();
      rd_issue(4'd0);
      n_cmp++;
      if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_busy: got v=%b, want 0", rd_valid); end
      feed(8'h00, 14, 0);
      tick();
   endtask

   task automatic test_reset_mid_capture();
      rd_issue(4'd8);
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h02) begin
         n_err++;
         $display("FAIL mid_pre: got v=%b d=%h, want v=1 d=02", rd_valid, rd_data);
      end
      pulse_start();
      feed(8'h40, 4, 0);
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({busy, frame_done, overflow, rd_valid, rd_data} !== 12'h000) begin
         n_err++;
         $display("FAIL mid_reset: got %h, want 000", {busy, frame_done, overflow, rd_valid, rd_data});
      end
      tick();
      rst = 1'b1;
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL mid_idle_busy: got %b, want 0", busy); end
      feed(8'h55, 1, 0);
      n_cmp++;
      if (overflow !== 1'b1) begin n_err++; $display("FAIL mid_idle_ovf: got %b, want 1", overflow); end
      rd_issue(4'd8);
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h42) begin
         n_err++;
         $display("FAIL mid_ram_kept: got v=%b d=%h, want v=1 d=42", rd_valid, rd_data);
      end
   endtask

   task automatic test_skip0_same_cycle();
      int         d0;
      logic [7:0] e;
      logic [3:0] addrs [4];
      logic [7:0] vals  [4];
      addrs[0] = 4'd8;  vals[0] = 8'hA5;
      addrs[1] = 4'd9;  vals[1] = 8'h01;
      addrs[2] = 4'd0;  vals[2] = 8'h08;
      addrs[3] = 4'd3;  vals[3] = 8'h0B;
      d0 = done0_cnt;
      s0_start       = 1'b1;
      s0_pixel_valid = 1'b1;
      s0_pixel_in    = 8'hA5;
      tick();
      s0_start       = 1'b0;
      s0_pixel_valid = 1'b0;
      n_cmp++;
      if (s0_busy !== 1'b1) begin n_err++; $display("FAIL s0_busy: got %b, want 1", s0_busy); end
      for (int i = 1; i < 12; i++) begin
         s0_pixel_valid = 1'b1;
         s0_pixel_in    = 8'(i);
         tick();
      end
      s0_pixel_valid = 1'b0;
      tick();
      n_cmp++;
      if (done0_cnt - d0 !== 1 || s0_busy !== 1'b0) begin
         n_err++;
         $display("FAIL s0_done: got done=%0d busy=%b, want done=1 busy=0", done0_cnt - d0, s0_busy);
      end
      for (int i = 0; i < 4; i++) begin
         sb.push_back(vals[i]);
         s0_rd_en   = 1'b1;
         s0_rd_addr = addrs[i];
         tick();
         s0_rd_en   = 1'b0;
         e = sb.pop_front();
         n_cmp++;
         if (s0_rd_valid !== 1'b1 || s0_rd_data !== e) begin
            n_err++;
            $display("FAIL s0_img addr %0d: got v=%b d=%h, want v=1 d=%h", addrs[i], s0_rd_valid, s0_rd_data, e);
         end
      end
   endtask

   initial begin
      start = 1'b0; pixel_valid = 1'b0; pixel_in = '0; rd_en = 1'b0; rd_addr = '0;
      s0_start = 1'b0; s0_pixel_valid = 1'b0; s0_pixel_in = '0; s0_rd_en = 1'b0; s0_rd_addr = '0;
      test_reset();
      test_full_frame();
      test_restart();
      test_gapped();
      test_overflow();
      test_readback();
      test_reset_mid_capture();
      test_skip0_same_cycle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
